// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg: shared encodings for the conditional-branch sequencer.
//   br_op_e  : branch type as captured from br_op (BEQ/BNE/BLE/BGT)
//   state_e  : sequencer phases (IDLE, TARGET, COMPARE, RESOLVE)
//   ALU_*    : alu_op codes driven toward the datapath
//   SRC*_*   : ALU mux and PC source selects
// -----------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BLE = 2'b10,
    BR_BGT = 2'b11
  } br_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_TARGET  = 2'b01,
    S_COMPARE = 2'b10,
    S_RESOLVE = 2'b11
  } state_e;

  localparam logic [2:0] ALU_LOAD = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_A    = 1'b1;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_OFFS = 2'b11;

  localparam logic [1:0] PCSRC_NONE   = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval: combinational branch-condition decode.
// Ports:
//   op    in  2  branch type (BR_BEQ/BR_BNE/BR_BLE/BR_BGT)
//   igual in  1  registered ALU equal flag
//   maior in  1  registered ALU signed greater-than flag
//   cond  out 1  1 when the branch is taken
// Flags are used literally, so igual=1 with maior=1 is not treated specially.
// -----------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [1:0] op,
  input  logic       igual,
  input  logic       maior,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (op)
      BR_BEQ:  cond = igual;
      BR_BNE:  cond = ~igual;
      BR_BLE:  cond = ~maior;
      BR_BGT:  cond = maior;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq.sv
// -----------------------------------------------------------------------------
// branch_seq: multicycle sequencer for BEQ/BNE/BLE/BGT.
// Phases after a start is accepted in IDLE:
//   TARGET  : ALUOut <= PC + (offset << 2)
//   COMPARE : ALU computes A - B, flags captured at the closing edge
//   RESOLVE : done pulse, PC written from ALUOut if the condition holds
// Outputs decode only from registered state (state, op, flags, counters),
// so there is no combinational input-to-output path.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, br_op          branch request and type (sampled in IDLE only)
//   igual, maior          ALU flags, valid during COMPARE
//   busy, done, taken     status (taken valid only with done)
//   alu_src_a/b, alu_op   ALU controls, aluout_write ALUOut load enable
//   pc_write, pc_src      PC load enable and source
//   taken_cnt, not_taken_cnt  branch statistics (CNT_W bits)
// Optional feature: define BRANCH_STATS_EN to build the saturating outcome
// counters; otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module branch_seq
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       br_op,
  input  logic             igual,
  input  logic             maior,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic             aluout_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  state_e     r_state;
  logic [1:0] r_op_q;
  logic       r_igual_q;
  logic       r_maior_q;
  logic       w_cond;

  // Sequencer state, captured op and captured flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op_q    <= 2'b00;
      r_igual_q <= 1'b0;
      r_maior_q <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op_q  <= br_op;
            r_state <= S_TARGET;
          end
        end
        S_TARGET:  r_state <= S_COMPARE;
        S_COMPARE: begin
          r_igual_q <= igual;
          r_maior_q <= maior;
          r_state   <= S_RESOLVE;
        end
        S_RESOLVE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  branch_cond_eval u_cond (
    .op    (r_op_q),
    .igual (r_igual_q),
    .maior (r_maior_q),
    .cond  (w_cond)
  );

  // Moore output decode from registered state only
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    taken        = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_B;
    alu_op       = ALU_LOAD;
    aluout_write = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PCSRC_NONE;
    case (r_state)
      S_TARGET: begin
        busy         = 1'b1;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_OFFS;
        alu_op       = ALU_ADD;
        aluout_write = 1'b1;
      end
      S_COMPARE: begin
        busy      = 1'b1;
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = ALU_SUB;
      end
      S_RESOLVE: begin
        busy     = 1'b1;
        done     = 1'b1;
        taken    = w_cond;
        pc_write = w_cond;
        pc_src   = w_cond ? PCSRC_ALUOUT : PCSRC_NONE;
      end
      default: ;
    endcase
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_not_taken_cnt;

  // Saturating outcome counters, updated once per resolved branch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_taken_cnt     <= '0;
      r_not_taken_cnt <= '0;
    end else if (r_state == S_RESOLVE) begin
      if (w_cond) begin
        if (r_taken_cnt != {CNT_W{1'b1}}) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end else begin
        if (r_not_taken_cnt != {CNT_W{1'b1}}) r_not_taken_cnt <= r_not_taken_cnt + CNT_W'(1);
      end
    end
  end

  assign taken_cnt     = r_taken_cnt;
  assign not_taken_cnt = r_not_taken_cnt;
`else
  assign taken_cnt     = '0;
  assign not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// -----------------------------------------------------------------------------
// tb_branch_seq: self-checking bench for branch_seq.
// A transaction-level reference (branch condition table, phase sequence,
// saturating outcome tallies) predicts every output; DUT outputs are sampled
// 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_branch_seq;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    br_op;
  logic          igual;
  logic          maior;
  logic          busy;
  logic          done;
  logic          taken;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic [2:0]    alu_op;
  logic          aluout_write;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic [CW-1:0] taken_cnt;
  logic [CW-1:0] not_taken_cnt;

  int errors = 0;
  int checks = 0;
  int m_taken = 0;
  int m_not   = 0;

  branch_seq #(.CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .br_op         (br_op),
    .igual         (igual),
    .maior         (maior),
    .busy          (busy),
    .done          (done),
    .taken         (taken),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .aluout_write  (aluout_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {busy,done,taken,src_a,src_b,alu_op,aluout_write,pc_write,pc_src}
  function automatic logic [12:0] pack_out();
    return {busy, done, taken, alu_src_a, alu_src_b, alu_op, aluout_write, pc_write, pc_src};
  endfunction

  function automatic logic [12:0] vec(input logic b, input logic d, input logic t,
                                      input logic sa, input logic [1:0] sb,
                                      input logic [2:0] op, input logic aw,
                                      input logic pw, input logic [1:0] ps);
    return {b, d, t, sa, sb, op, aw, pw, ps};
  endfunction

  // Branch condition table: BEQ, BNE, BLE, BGT
  function automatic logic ref_cond(input logic [1:0] op, input logic ig, input logic ma);
    case (op)
      2'd0:    return ig;
      2'd1:    return !ig;
      2'd2:    return !ma;
      default: return ma;
    endcase
  endfunction

  function automatic logic [12:0] v_resolve(input logic c);
    return vec(1'b1, 1'b1, c, 1'b0, 2'b00, 3'b000, 1'b0, c, c ? 2'b01 : 2'b00);
  endfunction

  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef BRANCH_STATS_EN
    int mx;
    mx = (1 << CW) - 1;
    return CW'((n > mx) ? mx : n);
`else
    return CW'(n * 0);
`endif
  endfunction

  localparam logic [12:0] V_IDLE    = 13'd0;
  localparam logic [12:0] V_TARGET  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 3'b001, 1'b1, 1'b0, 2'b00};
  localparam logic [12:0] V_COMPARE = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010, 1'b0, 1'b0, 2'b00};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full branch from IDLE, checking every phase and the return to IDLE
  task automatic test_branch(input logic [1:0] op, input logic ig, input logic ma, input string tag);
    logic c;
    c = ref_cond(op, ig, ma);
    start = 1'b1; br_op = op; igual = ~ig; maior = ~ma;
    checks++;
    if (pack_out() !== V_IDLE) begin
      errors++; $display("FAIL %s idle: got %h expected %h", tag, pack_out(), V_IDLE);
    end
    step();
    start = 1'($urandom_range(0, 1)); br_op = 2'($urandom); igual = ig; maior = ma;
    checks++;
    if (pack_out() !== V_TARGET) begin
      errors++; $display("FAIL %s target: got %h expected %h", tag, pack_out(), V_TARGET);
    end
    step();
    start = 1'($urandom_range(0, 1)); br_op = 2'($urandom);
    checks++;
    if (pack_out() !== V_COMPARE) begin
      errors++; $display("FAIL %s compare: got %h expected %h", tag, pack_out(), V_COMPARE);
    end
    step();
    start = 1'($urandom_range(0, 1)); igual = 1'($urandom); maior = 1'($urandom);
    checks++;
    if (pack_out() !== v_resolve(c)) begin
      errors++; $display("FAIL %s resolve: got %h expected %h", tag, pack_out(), v_resolve(c));
    end
    if (c) m_taken++; else m_not++;
    step();
    start = 1'b0;
    checks++;
    if (pack_out() !== V_IDLE) begin
      errors++; $display("FAIL %s back_idle: got %h expected %h", tag, pack_out(), V_IDLE);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; br_op = 2'b00; igual = 1'b0; maior = 1'b0;
    step(); step();
    reset = 1'b0;
    m_taken = 0; m_not = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (pack_out() !== V_IDLE || taken_cnt !== '0 || not_taken_cnt !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: got %h cnt %h/%h expected all zero",
                 i, pack_out(), taken_cnt, not_taken_cnt);
      end
    end
  endtask

  task automatic test_ops();
    test_branch(2'b00, 1'b1, 1'b0, "beq_taken");
    test_branch(2'b01, 1'b1, 1'b0, "bne_not_taken");
    test_branch(2'b10, 1'b0, 1'b0, "ble_taken");
    test_branch(2'b11, 1'b0, 1'b0, "bgt_not_taken");
    test_branch(2'b11, 1'b0, 1'b1, "bgt_taken");
    test_branch(2'b10, 1'b1, 1'b1, "ble_illegal_flags");
    test_branch(2'b00, 1'b1, 1'b1, "beq_illegal_flags");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      test_branch(2'($urandom), 1'($urandom), 1'($urandom), "random");
    checks++;
    if (taken_cnt !== exp_cnt(m_taken) || not_taken_cnt !== exp_cnt(m_not)) begin
      errors++;
      $display("FAIL random_counters: got %h/%h expected %h/%h",
               taken_cnt, not_taken_cnt, exp_cnt(m_taken), exp_cnt(m_not));
    end
  endtask

  // start held high: one acceptance every 4 cycles; br_op flip after accept is ignored
  task automatic test_back_to_back();
    logic [12:0] exp;
    start = 1'b1; br_op = 2'b11; igual = 1'b0; maior = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      case (i % 4)
        0:       exp = V_TARGET;
        1:       exp = V_COMPARE;
        2:       exp = v_resolve(1'b1);
        default: exp = V_IDLE;
      endcase
      checks++;
      if (pack_out() !== exp) begin
        errors++; $display("FAIL back_to_back cyc %0d: got %h expected %h", i, pack_out(), exp);
      end
      if (i % 4 == 1) br_op = 2'b00;
      if (i % 4 == 2) m_taken++;
      if (i % 4 == 3) br_op = 2'b11;
    end
    start = 1'b0;
    step();
  endtask

  // Reset during COMPARE aborts the branch with no PC update
  task automatic test_reset_mid();
    start = 1'b1; br_op = 2'b00; igual = 1'b1; maior = 1'b0;
    step();
    start = 1'b0;
    step();
    checks++;
    if (pack_out() !== V_COMPARE) begin
      errors++; $display("FAIL reset_mid compare: got %h expected %h", pack_out(), V_COMPARE);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_taken = 0; m_not = 0;
    checks++;
    if (pack_out() !== V_IDLE) begin
      errors++; $display("FAIL reset_mid after: got %h expected %h", pack_out(), V_IDLE);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (pack_out() !== V_IDLE) begin
        errors++; $display("FAIL reset_mid idle cyc %0d: got %h expected %h", i, pack_out(), V_IDLE);
      end
    end
  endtask

  task automatic test_stats();
    checks++;
    if (taken_cnt !== exp_cnt(0) || not_taken_cnt !== exp_cnt(0)) begin
      errors++; $display("FAIL stats_cleared: got %h/%h expected 0/0", taken_cnt, not_taken_cnt);
    end
    for (int i = 0; i < 5; i++) test_branch(2'b00, 1'b1, 1'b0, "stats_taken");
    checks++;
    if (taken_cnt !== exp_cnt(m_taken) || not_taken_cnt !== exp_cnt(m_not)) begin
      errors++;
      $display("FAIL stats_saturate: got %h/%h expected %h/%h",
               taken_cnt, not_taken_cnt, exp_cnt(m_taken), exp_cnt(m_not));
    end
    test_branch(2'b01, 1'b1, 1'b0, "stats_not_taken");
    checks++;
    if (taken_cnt !== exp_cnt(m_taken) || not_taken_cnt !== exp_cnt(m_not)) begin
      errors++;
      $display("FAIL stats_not_taken: got %h/%h expected %h/%h",
               taken_cnt, not_taken_cnt, exp_cnt(m_taken), exp_cnt(m_not));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; br_op = 2'b00; igual = 1'b0; maior = 1'b0;
    test_reset();
    test_ops();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
